// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit full-adder slice is reused over
// NCHUNK cycles, LSB chunk first, with a valid/ready handshake on both sides.
module chunked_serial_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   input  logic             SUB,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] S,
   output logic             COUT,
   output logic             OVF
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   slice;
   logic             msb_carry_in;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      s_d     = s_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      a_chunk = a_q[idx_q*CHUNK +: CHUNK];
      b_chunk = b_q[idx_q*CHUNK +: CHUNK];
      slice   = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
      // Carry into the top bit of the slice, recovered from its sum bit.
      msb_carry_in = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ slice[CHUNK-1];

      case (state_q)
         IDLE: begin
            if (IN_VALID) begin
               // Subtraction is A + ~B + 1, so the +1 rides in on the carry.
               a_d     = A;
               b_d     = SUB ? ~B : B;
               carry_d = SUB ? 1'b1 : CIN;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[idx_q*CHUNK +: CHUNK] = slice[CHUNK-1:0];
            carry_d = slice[CHUNK];
            if (idx_q == LAST_IDX) begin
               cout_d  = slice[CHUNK];
               ovf_d   = msb_carry_in ^ slice[CHUNK];
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            if (OUT_READY) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign IN_READY  = (state_q == IDLE);
   assign OUT_VALID = (state_q == DONE);
   assign S         = s_q;
   assign COUT      = cout_q;
   assign OVF       = ovf_q;

endmodule

// File: doc/chunked_serial_adder.md
CHUNKED_SERIAL_ADDER -- requirements
Module: chunked_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL have port CLK, input, 1: single clock, rising edge.
REQ-004 The block SHALL have port RST_N, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have port IN_VALID, input, 1: operands valid.
REQ-006 The block SHALL have port IN_READY, output, 1: block accepts operands.
REQ-007 The block SHALL have ports A and B, input, WIDTH each: operands.
REQ-008 The block SHALL have port CIN, input, 1: carry-in, add mode only.
REQ-009 The block SHALL have port SUB, input, 1: 0 = A+B+CIN; 1 = A-B.
REQ-010 The block SHALL have port OUT_VALID, output, 1: result valid.
REQ-011 The block SHALL have port OUT_READY, input, 1: consumer accepts result.
REQ-012 The block SHALL have port S, output, WIDTH: sum/difference.
REQ-013 The block SHALL have port COUT, output, 1: carry out of MSB; in SUB mode 1 = no borrow.
REQ-014 The block SHALL have port OVF, output, 1: two's-complement signed overflow.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE, IN_READY SHALL be 1 and OUT_VALID SHALL be 0.
REQ-017 Capture in IDLE with IN_VALID=1 at edge t:
- latch A and (SUB ? ~B : B);
- set carry register = (SUB ? 1 : CIN); CIN is ignored when SUB=1;
- clear chunk index to 0;
- go to RUN.
REQ-018 In RUN, each edge SHALL add chunk k of both latched operands plus the carry register, LSB chunk first, using a CHUNK-bit full-adder slice.
- Write the CHUNK-bit result into S bits [k*CHUNK +: CHUNK].
- Update the carry register with the slice carry-out.
- Increment k.
REQ-019 After chunk NCHUNK-1 is processed at edge t+NCHUNK, the FSM SHALL go to DONE.
- Latency from capture edge to OUT_VALID=1 is exactly NCHUNK cycles.
- For NCHUNK=1 the latency is 1 cycle.
REQ-020 COUT SHALL equal the carry out of bit WIDTH-1.
REQ-021 OVF SHALL equal (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1); it is registered with the last chunk.
REQ-022 IN_READY SHALL be 0 in RUN and DONE; IN_VALID asserted there SHALL be ignored and SHALL NOT be queued.
REQ-023 In DONE, OUT_VALID SHALL be 1, and S, COUT and OVF SHALL be held stable until OUT_READY=1 is sampled.
REQ-024 On that edge (OUT_VALID and OUT_READY both 1) the FSM SHALL return to IDLE; OUT_VALID falls on that edge.
REQ-025 No back-to-back overlap: the earliest next capture is the edge after the one returning to IDLE.
REQ-026 S, COUT and OVF SHALL retain the last result in IDLE until the next capture; during RUN, S shows partial results.
REQ-027 A, B, CIN and SUB SHALL be sampled only at the capture edge; changes afterwards have no effect.

Reset
REQ-028 While RST_N=0, asynchronously and regardless of state:
- state = IDLE;
- S = 0, COUT = 0, OVF = 0, OUT_VALID = 0;
- carry register = 0, chunk index = 0;
- IN_READY = 1.
REQ-029 Reset asserted mid-RUN or mid-DONE SHALL abort the operation with no result produced; the first capture is possible on the first rising edge after RST_N rises.

Verification
REQ-030 Reset abort: capture 0x12345678+0x1, assert RST_N=0 after 2 cycles -> OUT_VALID=0, S=0, IN_READY=1 immediately; no OUT_VALID after release.
REQ-031 Full ripple (WIDTH=32, CHUNK=8): 0xFFFFFFFF+0x00000001, CIN=0 -> S=0x00000000, COUT=1, OVF=0; OUT_VALID exactly 4 cycles after capture.
REQ-032 Signed overflow: 0x7FFFFFFF+0x00000001 -> S=0x80000000, COUT=0, OVF=1; also 0x80000000-0x00000001 (SUB=1) -> S=0x7FFFFFFF, COUT=1, OVF=1.
REQ-033 Subtract and borrow: SUB=1, A=5, B=7, CIN=1 (ignored) -> S=0xFFFFFFFE, COUT=0, OVF=0.
REQ-034 Chunk-boundary carry: A=0x000000FF, B=0x000000FF, CIN=1 -> S=0x000001FF, COUT=0.
REQ-035 Backpressure: hold OUT_READY=0 for 3 cycles in DONE while pulsing IN_VALID with new operands -> S, COUT and OVF unchanged, IN_READY=0, pulsed operands not captured; OUT_READY=1 -> IDLE the next edge.
- Repeat with WIDTH=8, CHUNK=8: 0x7F+0x01 -> S=0x80, OVF=1, latency 1 cycle.
